// File: rtl/persiana_pkg.sv
// Shared types and helpers for the multi-level blind controller:
// FSM state encoding, index width helper and limit-switch decoder.
package persiana_pkg;
   localparam int MAX_NIVELES = 32;
   localparam int IDX_W       = 5;

   typedef enum logic [2:0] {REPOSO, SUBIENDO, BAJANDO, PAUSA, FALLA} estado_t;

   typedef struct packed {
      logic             valido;    // exactly one switch active
      logic             invalido;  // two or more switches active
      logic [IDX_W-1:0] indice;
   } codigo_t;

   // Index width for n positions; never narrower than one bit.
   function automatic int ancho(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic codigo_t decodificar(input logic [MAX_NIVELES-1:0] v);
      codigo_t r;
      int      cuenta;
      r      = '0;
      cuenta = 0;
      for (int i = MAX_NIVELES-1; i >= 0; i--) begin
         if (v[i]) begin
            r.indice = IDX_W'(i);
            cuenta   = cuenta + 1;
         end
      end
      r.valido   = (cuenta == 1);
      r.invalido = (cuenta > 1);
      return r;
   endfunction
endpackage

// File: rtl/persiana_objetivo.sv
// Target selection: lowest pressed level button in manual mode, inverted
// light-sensor scaling in automatic mode, held in the objetivo register.
module persiana_objetivo
   import persiana_pkg::*;
#(
   parameter int NIVELES  = 4,
   parameter int SENSOR_W = 2
) (
   input  logic                      Reloj,
   input  logic                      reset,
   input  logic                      automatico,
   input  logic [NIVELES-1:0]        btn_nivel,
   input  logic [SENSOR_W-1:0]       sensor,
   output logic [ancho(NIVELES)-1:0] objetivo
);
   localparam int OW = ancho(NIVELES);
   localparam int PW = SENSOR_W + 32;

   logic [SENSOR_W-1:0] inverso;
   logic [PW-1:0]       producto;
   logic [PW-1:0]       escalado;
   logic [OW-1:0]       nivel_auto;
   logic [OW-1:0]       nivel_btn;

   // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      inverso  = ~sensor;
      producto = PW'(inverso) * PW'(NIVELES);
      escalado = producto >> SENSOR_W;
      if (escalado > PW'(NIVELES - 1))
         nivel_auto = OW'(NIVELES - 1);
      else
         nivel_auto = OW'(escalado);

      // Scanning downward lets the lowest pressed button win.
      nivel_btn = '0;
      for (int i = NIVELES-1; i >= 0; i--) begin
         if (btn_nivel[i])
            nivel_btn = OW'(i);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
   always_ff @(posedge Reloj or negedge reset) begin
      if (!reset)
         objetivo <= '0;
      else if (automatico)
         objetivo <= nivel_auto;
      else if (|btn_nivel)
         objetivo <= nivel_btn;
   end
endmodule

// File: rtl/persiana_niveles.sv
// Multi-level motorised blind controller: position tracking, motor FSM
// with dead time on every stop, travel watchdog and sticky fault.
module persiana_niveles
   import persiana_pkg::*;
#(
   parameter int NIVELES  = 4,
   parameter int SENSOR_W = 2,
   parameter int TIMEOUT  = 1000,
   parameter int MUERTO   = 4
) (
   input  logic                      Reloj,
   input  logic                      reset,
   input  logic                      automatico,
   input  logic [NIVELES-1:0]        btn_nivel,
   input  logic [SENSOR_W-1:0]       sensor,
   input  logic [NIVELES-1:0]        fin_carrera,
   output logic                      subir,
   output logic                      bajar,
   output logic [ancho(NIVELES)-1:0] posicion,
   output logic [ancho(NIVELES)-1:0] objetivo,
   output logic                      falla
);
   localparam int OW = ancho(NIVELES);
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam int MW = $clog2(MUERTO + 1);

   estado_t                estado;
   estado_t                estado_sig;
   logic [WW-1:0]          vigia;
   logic [MW-1:0]          muerto;
   logic [MAX_NIVELES-1:0] fc_ext;
   codigo_t                fc;
   logic                   cambio_pos;
   logic                   en_marcha;
   logic                   llegada;
   logic                   agotado;

   persiana_objetivo #(
      .NIVELES  (NIVELES),
      .SENSOR_W (SENSOR_W)
   ) u_objetivo (
      .Reloj      (Reloj),
      .reset      (reset),
      .automatico (automatico),
      .btn_nivel  (btn_nivel),
      .sensor     (sensor),
      .objetivo   (objetivo)
   );

   always_comb begin
      fc_ext     = MAX_NIVELES'(fin_carrera);
      fc         = decodificar(fc_ext);
      cambio_pos = fc.valido && (fc.indice != IDX_W'(posicion));
      en_marcha  = (estado == SUBIENDO) || (estado == BAJANDO);
      llegada    = fin_carrera[objetivo];
      // Reaching a new level in the same cycle beats the timeout.
      agotado    = (vigia == WW'(TIMEOUT - 1)) && !cambio_pos;
   end

   always_comb begin
      estado_sig = estado;
      if (fc.invalido) begin
         estado_sig = FALLA;
      end else begin
         case (estado)
            REPOSO: begin
               if (objetivo > posicion)
                  estado_sig = SUBIENDO;
               else if (objetivo < posicion)
                  estado_sig = BAJANDO;
            end
            SUBIENDO: begin
               if (llegada || (objetivo <= posicion))
                  estado_sig = PAUSA;
               else if (agotado)
                  estado_sig = FALLA;
            end
            BAJANDO: begin
               if (llegada || (objetivo >= posicion))
                  estado_sig = PAUSA;
               else if (agotado)
                  estado_sig = FALLA;
            end
            PAUSA: begin
               if (muerto == MW'(MUERTO - 1))
                  estado_sig = REPOSO;
            end
            FALLA:   estado_sig = FALLA;
            default: estado_sig = FALLA;
         endcase
      end
   end

   always_ff @(posedge Reloj or negedge reset) begin
      if (!reset) begin
         estado   <= REPOSO;
         posicion <= '0;
         vigia    <= '0;
         muerto   <= '0;
         subir    <= 1'b0;
         bajar    <= 1'b0;
         falla    <= 1'b0;
      end else begin
         estado <= estado_sig;
         if (fc.valido)
            posicion <= OW'(fc.indice);

         // Zero outside motion, so each move starts its watchdog from zero.
         if (!en_marcha || cambio_pos)
            vigia <= '0;
         else
            vigia <= vigia + 1'b1;

         if (estado != PAUSA)
            muerto <= '0;
         else
            muerto <= muerto + 1'b1;

         // Outputs come from the next state so they change on the deciding edge.
         subir <= (estado_sig == SUBIENDO);
         bajar <= (estado_sig == BAJANDO);
         falla <= (estado_sig == FALLA);
      end
   end
endmodule

// File: tb/tb_persiana_niveles.sv
// Self-checking bench for persiana_niveles: expected output words are queued
// with each stimulus step and popped for comparison after the clock edge.
module tb_persiana_niveles;
   localparam int NIVELES  = 4;
   localparam int SENSOR_W = 2;
   localparam int TIMEOUT  = 1000;
   localparam int MUERTO   = 4;

   logic       Reloj = 1'b0;
   logic       reset = 1'b0;
   logic       automatico = 1'b0;
   logic [3:0] btn_nivel = '0;
   logic [1:0] sensor = '0;
   logic [3:0] fin_carrera = '0;
   logic       subir;
   logic       bajar;
   logic [1:0] posicion;
   logic [1:0] objetivo;
   logic       falla;

   // Scoreboard word: {subir, bajar, falla, posicion, objetivo}
   logic [6:0] sb[$];
   logic [6:0] esperado;
   logic [6:0] observado;
   int         pasa  = 0;
   int         total = 0;

   persiana_niveles #(
      .NIVELES  (NIVELES),
      .SENSOR_W (SENSOR_W),
      .TIMEOUT  (TIMEOUT),
      .MUERTO   (MUERTO)
   ) dut (
      .Reloj       (Reloj),
      .reset       (reset),
      .automatico  (automatico),
      .btn_nivel   (btn_nivel),
      .sensor      (sensor),
      .fin_carrera (fin_carrera),
      .subir       (subir),
      .bajar       (bajar),
      .posicion    (posicion),
      .objetivo    (objetivo),
      .falla       (falla)
   );

   always #5 Reloj = ~Reloj;

   task automatic ciclo();
      @(posedge Reloj);
      #1;
   endtask

   task automatic aplica_reset();
      reset       = 1'b0;
      automatico  = 1'b0;
      btn_nivel   = '0;
      sensor      = '0;
      fin_carrera = '0;
      ciclo();
      reset = 1'b1;
   endtask

   function automatic logic [1:0] mapa_sensor(input int s);
      int v;
      v = (((1 << SENSOR_W) - 1 - s) * NIVELES) >> SENSOR_W;
      if (v > NIVELES - 1) v = NIVELES - 1;
      return 2'(v);
   endfunction

   task automatic test_reset();
      reset = 1'b0;
      #2;
      sb.push_back(7'b000_00_00);
      esperado  = sb.pop_front();
      observado = {subir, bajar, falla, posicion, objetivo};
      total++;
      if (observado !== esperado)
         $display("FAIL reset: got %b expected %b", observado, esperado);
      else
         pasa++;
      aplica_reset();
   endtask

   task automatic test_subida_manual();
      logic [3:0] fin_t [0:11];
      logic [3:0] btn_t [0:11];
      logic [6:0] exp_t [0:11];
      fin_t = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0000,
                4'b0100, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000};
      btn_t = '{4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      exp_t = '{7'b000_00_00, 7'b000_00_11, 7'b100_00_11, 7'b100_00_11,
                7'b100_01_11, 7'b100_01_11, 7'b100_10_11, 7'b000_11_11,
                7'b000_11_11, 7'b000_11_11, 7'b000_11_11, 7'b000_11_11};
      aplica_reset();
      for (int i = 0; i < 12; i++) begin
         fin_carrera = fin_t[i];
         btn_nivel   = btn_t[i];
         sb.push_back(exp_t[i]);
         ciclo();
         esperado  = sb.pop_front();
         observado = {subir, bajar, falla, posicion, objetivo};
         total++;
         if (observado !== esperado)
            $display("FAIL subida paso %0d: got %b expected %b", i, observado, esperado);
         else
            pasa++;
      end
   endtask

   task automatic test_inversion();
      logic [3:0] fin_t [0:11];
      logic [3:0] btn_t [0:11];
      logic [6:0] exp_t [0:11];
      fin_t = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000,
                4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
      btn_t = '{4'b0010, 4'b1000, 4'b0000, 4'b0000, 4'b0001, 4'b0000,
                4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      exp_t = '{7'b000_01_01, 7'b000_01_11, 7'b100_01_11, 7'b100_01_11,
                7'b100_01_00, 7'b000_01_00, 7'b000_01_00, 7'b000_01_00,
                7'b000_01_00, 7'b000_01_00, 7'b010_01_00, 7'b000_00_00};
      aplica_reset();
      for (int i = 0; i < 12; i++) begin
         fin_carrera = fin_t[i];
         btn_nivel   = btn_t[i];
         sb.push_back(exp_t[i]);
         ciclo();
         esperado  = sb.pop_front();
         observado = {subir, bajar, falla, posicion, objetivo};
         total++;
         if (observado !== esperado)
            $display("FAIL inversion paso %0d: got %b expected %b", i, observado, esperado);
         else
            pasa++;
      end
   endtask

   task automatic test_automatico();
      int sens_t [0:4];
      sens_t = '{3, 0, 1, 2, 3};
      aplica_reset();
      automatico  = 1'b1;
      fin_carrera = 4'b0001;
      for (int i = 0; i < 5; i++) begin
         sensor    = 2'(sens_t[i]);
         btn_nivel = 4'b1000 >> i;
         sb.push_back({5'b0, mapa_sensor(sens_t[i])});
         ciclo();
         esperado = sb.pop_front();
         total++;
         if (objetivo !== esperado[1:0])
            $display("FAIL automatico sensor=%0d: got %0d expected %0d",
                     sens_t[i], objetivo, esperado[1:0]);
         else
            pasa++;
      end
   endtask

   task automatic test_watchdog();
      aplica_reset();
      fin_carrera = 4'b0001;
      btn_nivel   = 4'b1000;
      ciclo();
      btn_nivel   = 4'b0000;
      fin_carrera = 4'b0000;
      sb.push_back(7'b100_00_11);
      ciclo();
      esperado  = sb.pop_front();
      observado = {subir, bajar, falla, posicion, objetivo};
      total++;
      if (observado !== esperado)
         $display("FAIL watchdog arranque: got %b expected %b", observado, esperado);
      else
         pasa++;
      sb.push_back(7'b100_00_11);
      for (int i = 1; i < TIMEOUT; i++) ciclo();
      esperado  = sb.pop_front();
      observado = {subir, bajar, falla, posicion, objetivo};
      total++;
      if (observado !== esperado)
         $display("FAIL watchdog antes: got %b expected %b", observado, esperado);
      else
         pasa++;
      sb.push_back(7'b001_00_11);
      ciclo();
      esperado  = sb.pop_front();
      observado = {subir, bajar, falla, posicion, objetivo};
      total++;
      if (observado !== esperado)
         $display("FAIL watchdog disparo: got %b expected %b", observado, esperado);
      else
         pasa++;
      btn_nivel = 4'b0010;
      sb.push_back(7'b001_00_01);
      for (int i = 0; i < 3; i++) ciclo();
      esperado  = sb.pop_front();
      observado = {subir, bajar, falla, posicion, objetivo};
      total++;
      if (observado !== esperado)
         $display("FAIL watchdog persiste: got %b expected %b", observado, esperado);
      else
         pasa++;
      aplica_reset();
      sb.push_back(7'b000_00_00);
      esperado  = sb.pop_front();
      observado = {subir, bajar, falla, posicion, objetivo};
      total++;
      if (observado !== esperado)
         $display("FAIL watchdog tras reset: got %b expected %b", observado, esperado);
      else
         pasa++;
   endtask

   task automatic test_invalido();
      logic [3:0] fin_t [0:2];
      logic [6:0] exp_t [0:2];
      fin_t = '{4'b0001, 4'b0110, 4'b0001};
      exp_t = '{7'b000_00_00, 7'b001_00_00, 7'b001_00_00};
      aplica_reset();
      for (int i = 0; i < 3; i++) begin
         fin_carrera = fin_t[i];
         sb.push_back(exp_t[i]);
         ciclo();
         esperado  = sb.pop_front();
         observado = {subir, bajar, falla, posicion, objetivo};
         total++;
         if (observado !== esperado)
            $display("FAIL invalido paso %0d: got %b expected %b", i, observado, esperado);
         else
            pasa++;
      end
   endtask

   task automatic test_reset_async();
      logic [6:0] exp_t [0:1];
      exp_t = '{7'b000_10_00, 7'b010_10_00};
      aplica_reset();
      fin_carrera = 4'b0100;
      for (int i = 0; i < 2; i++) begin
         sb.push_back(exp_t[i]);
         ciclo();
         esperado  = sb.pop_front();
         observado = {subir, bajar, falla, posicion, objetivo};
         total++;
         if (observado !== esperado)
            $display("FAIL async previo paso %0d: got %b expected %b", i, observado, esperado);
         else
            pasa++;
      end
      #2;
      reset = 1'b0;
      sb.push_back(7'b000_00_00);
      #1;
      esperado  = sb.pop_front();
      observado = {subir, bajar, falla, posicion, objetivo};
      total++;
      if (observado !== esperado)
         $display("FAIL async en reset: got %b expected %b", observado, esperado);
      else
         pasa++;
      ciclo();
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         sb.push_back(exp_t[i]);
         ciclo();
         esperado  = sb.pop_front();
         observado = {subir, bajar, falla, posicion, objetivo};
         total++;
         if (observado !== esperado)
            $display("FAIL async reanuda paso %0d: got %b expected %b", i, observado, esperado);
         else
            pasa++;
      end
   endtask

   initial begin
      test_reset();
      test_subida_manual();
      test_inversion();
      test_automatico();
      test_watchdog();
      test_invalido();
      test_reset_async();
      $display("%0d/%0d checks passed", pasa, total);
      $finish;
   end
endmodule

// File: doc/persiana_niveles.md
# persiana_niveles

Parametrised successor of the two-FSM blind controller: a single-clock block that drives a motorised blind to one of `NIVELES` discrete positions. It takes the target either from manual level buttons or from a light sensor in automatic mode. It commands the motor with mutually exclusive `subir`/`bajar` outputs and enforces a dead time on every stop or reversal. A travel watchdog latches a fault on stalls or invalid limit-switch patterns.

## Interface
- `NIVELES`, 4 — number of positions (≥2); index 0 = cerrada, `NIVELES-1` = abierta
- `SENSOR_W`, 2 — light sensor width (≥1)
- `TIMEOUT`, 1000 — max cycles of motion without reaching a new level (≥2)
- `MUERTO`, 4 — motor-off dead-time cycles after any stop (≥1)

Ports:
- `Reloj`  in  1  — single clock, rising edge
- `reset`  in  1  — asynchronous, active-low
- `automatico`  in  1  — 1 = target from `sensor`, buttons ignored
- `btn_nivel`  in  NIVELES  — manual level request, bit i = level i
- `sensor`  in  SENSOR_W  — light level, max = brightest
- `fin_carrera`  in  NIVELES  — limit switches, bit i = blind at level i
- `subir`  out  1  — motor up
- `bajar`  out  1  — motor down
- `posicion`  out  clog2(NIVELES)  — last confirmed level
- `objetivo`  out  clog2(NIVELES)  — current target
- `falla`  out  1  — sticky fault flag

## Operation
- Reset values: `subir`=`bajar`=0, `posicion`=0, `objetivo`=0, `falla`=0. State = REPOSO, counters cleared.
- Target, manual (`automatico`=0):
  - Any nonzero `btn_nivel` loads `objetivo` with the index of the lowest set bit.
  - Zero holds the current target.
- Target, automatic (`automatico`=1): `objetivo` = ((2^SENSOR_W−1 − sensor)·NIVELES) >> SENSOR_W, reloaded every cycle. Brightest maps to 0; darkest maps to NIVELES−1 when NIVELES ≤ 2^SENSOR_W. Saturate at NIVELES−1 otherwise.
- Position:
  - Exactly one bit of `fin_carrera` set: `posicion` loads that index.
  - All zero: between levels, hold.
  - ≥2 bits set: → FALLA.
- States: REPOSO, SUBIENDO, BAJANDO, PAUSA, FALLA.
  - REPOSO:
    - `objetivo` > `posicion` → SUBIENDO.
    - `objetivo` < `posicion` → BAJANDO.
    - Equal → stay.
  - SUBIENDO/BAJANDO:
    - `fin_carrera[objetivo]`=1 → PAUSA.
    - `objetivo` now on the opposite side of, or equal to, `posicion` → PAUSA (reversal always passes through the dead time).
    - Watchdog reaches TIMEOUT → FALLA.
  - PAUSA: motor off for exactly MUERTO cycles, then REPOSO.
  - FALLA: motor off, `falla`=1. Only `reset` exits.
- Watchdog: clears on entering a motion state and whenever `posicion` changes. Increments each cycle in SUBIENDO/BAJANDO.
- `subir` = 1 iff state SUBIENDO; `bajar` = 1 iff state BAJANDO. Both are registered and never 1 simultaneously.

## Timing
- Button or sensor sampled at edge k → `objetivo` updated after edge k. FSM leaves REPOSO at edge k+1, so `subir`/`bajar` are high from edge k+1: 2-cycle request-to-motor latency.
- `fin_carrera[objetivo]` rising sampled at edge m → motor off after edge m. `posicion` is updated at the same edge.
- Stop-to-restart: minimum MUERTO+1 cycles of motor off between opposite directions.
- Invalid `fin_carrera` (≥2 bits) sampled at edge m → `falla`=1 and motor off after edge m, in any state.
- Target change while moving in the same direction toward a farther level: no stop, motion continues.
- `reset` low asynchronously forces all outputs to reset values mid-motion. The first motion after release needs 2 cycles as above.

## Structure
- Package `persiana_pkg`: state enum `estado_t`, width helper for clog2, and a function mapping a one-hot `fin_carrera` to its index plus a valid flag.
- Sub-module `persiana_objetivo`: target selection (button priority encoder + sensor mapping) and the `objetivo` register.
- The top holds position tracking, the motor FSM, the watchdog and the dead-time counter.

## Test plan
- Manual up: reset, `posicion`=0 via `fin_carrera`=0001, `btn_nivel`=1000 → `subir`=1 two cycles later. Assert 0010, 0100 in turn, then 1000 → `subir`=0 same edge, `posicion`=3, 4 PAUSA cycles.
- Reversal: moving up toward 3 from level 1; press `btn_nivel`=0001 → `subir` drops next cycle, 4 cycles off, then `bajar`=1. Never both high.
- Automatic: `automatico`=1, `sensor`=3 → `objetivo`=0; `sensor`=0 → `objetivo`=3; `sensor`=1 → `objetivo`=2. `btn_nivel` ignored throughout.
- Watchdog: command up and hold `fin_carrera`=0000 for TIMEOUT cycles → `falla`=1, `subir`=0. Fault persists until `reset` pulses low.
- Invalid switches: `fin_carrera`=0110 while in REPOSO → `falla`=1 next edge.
- Async reset mid-motion: drop `reset` between clock edges while `bajar`=1 → `bajar`=0 immediately, `posicion`=`objetivo`=0.
